// File: rtl/sram_stage_scheduler_pkg.sv
// Shared types for the image decompressor stage scheduler: state and owner
// encodings plus SRAM bus widths.
package sram_stage_scheduler_pkg;

    localparam int unsigned SRAM_ADDR_W = 18;
    localparam int unsigned SRAM_DATA_W = 16;

    // Scheduler states; the encoding is visible on the stage output.
    typedef enum logic [2:0] {
        S_SCHED_IDLE    = 3'd0,
        S_SCHED_GUARD   = 3'd1,
        S_SCHED_UART    = 3'd2,
        S_SCHED_M2      = 3'd3,
        S_SCHED_M1      = 3'd4,
        S_SCHED_DISPLAY = 3'd5,
        S_SCHED_ERROR   = 3'd6
    } sched_state_e;

    // Which client currently drives the SRAM port.
    typedef enum logic [2:0] {
        OWN_NONE = 3'd0,
        OWN_UART = 3'd1,
        OWN_M2   = 3'd2,
        OWN_M1   = 3'd3,
        OWN_VGA  = 3'd4
    } owner_e;

    // Stage entered once the guard interval expires.
    typedef enum logic [1:0] {
        NEXT_UART    = 2'd0,
        NEXT_M2      = 2'd1,
        NEXT_M1      = 2'd2,
        NEXT_DISPLAY = 2'd3
    } next_stage_e;

    // Fixed stage order: UART load, M2 (IDCT), M1 (CSC), then display.
    function automatic next_stage_e follow_stage(input sched_state_e cur);
        case (cur)
            S_SCHED_UART: follow_stage = NEXT_M2;
            S_SCHED_M2:   follow_stage = NEXT_M1;
            default:      follow_stage = NEXT_DISPLAY;
        endcase
    endfunction

endpackage

// File: rtl/sram_port_mux.sv
// Combinational SRAM port multiplexer: the current owner's bus goes straight
// to the SRAM pins with no added latency.
module sram_port_mux
    import sram_stage_scheduler_pkg::*;
(
    input  logic [2:0]  owner,
    input  logic [17:0] uart_address,
    input  logic [15:0] uart_write_data,
    input  logic        uart_we_n,
    input  logic [17:0] m2_address,
    input  logic [15:0] m2_write_data,
    input  logic        m2_we_n,
    input  logic [17:0] m1_address,
    input  logic [15:0] m1_write_data,
    input  logic        m1_we_n,
    input  logic [17:0] vga_address,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n
);

    // Route the owning client; no owner parks the bus with writes disabled.
    always_comb begin
        SRAM_address    = '0;
        SRAM_write_data = '0;
        SRAM_we_n       = 1'b1;
        case (owner)
            OWN_UART: begin
                SRAM_address    = uart_address;
                SRAM_write_data = uart_write_data;
                SRAM_we_n       = uart_we_n;
            end
            OWN_M2: begin
                SRAM_address    = m2_address;
                SRAM_write_data = m2_write_data;
                SRAM_we_n       = m2_we_n;
            end
            OWN_M1: begin
                SRAM_address    = m1_address;
                SRAM_write_data = m1_write_data;
                SRAM_we_n       = m1_we_n;
            end
            // VGA is a read-only client, so write enable stays inactive.
            OWN_VGA: SRAM_address = vga_address;
            default: ;
        endcase
    end

endmodule

// File: rtl/sram_stage_scheduler.sv
// Top-level stage sequencer and SRAM port owner: UART load, M2, M1, then VGA
// display, with a guard interval at every handover and a compute watchdog.
module sram_stage_scheduler
    import sram_stage_scheduler_pkg::*;
#(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd4000000,
    parameter int unsigned GUARD_CYCLES   = 2
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        start,
    output logic        uart_enable,
    input  logic        uart_done,
    input  logic [17:0] uart_address,
    input  logic [15:0] uart_write_data,
    input  logic        uart_we_n,
    output logic        m2_enable,
    input  logic        m2_done,
    input  logic [17:0] m2_address,
    input  logic [15:0] m2_write_data,
    input  logic        m2_we_n,
    output logic        m1_enable,
    input  logic        m1_done,
    input  logic [17:0] m1_address,
    input  logic [15:0] m1_write_data,
    input  logic        m1_we_n,
    input  logic [17:0] vga_address,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    output logic [2:0]  stage,
    output logic        busy,
    output logic        error
);

    localparam logic [1:0] GUARD_LAST = 2'(GUARD_CYCLES - 1);

    sched_state_e state_q, state_d;
    next_stage_e  next_stage_q, next_stage_d;
    owner_e       owner_q, owner_d;
    logic [1:0]   guard_cnt_q, guard_cnt_d;
    logic [23:0]  wd_q, wd_d;
    logic         uart_en_q, uart_en_d;
    logic         m2_en_q, m2_en_d;
    logic         m1_en_q, m1_en_d;
    logic         error_q, error_d;
    logic         stage_done;

    // Only the done pulse belonging to the running stage is honoured.
    always_comb begin
        stage_done = 1'b0;
        case (state_q)
            S_SCHED_UART: stage_done = uart_done;
            S_SCHED_M2:   stage_done = m2_done;
            S_SCHED_M1:   stage_done = m1_done;
            default:      stage_done = 1'b0;
        endcase
    end

    // Next-state logic; owner and enables are computed for the state being entered.
    always_comb begin
        state_d      = state_q;
        next_stage_d = next_stage_q;
        owner_d      = owner_q;
        guard_cnt_d  = guard_cnt_q;
        wd_d         = wd_q;
        error_d      = error_q;
        uart_en_d    = 1'b0;
        m2_en_d      = 1'b0;
        m1_en_d      = 1'b0;
        unique case (state_q)
            S_SCHED_IDLE: begin
                if (start) begin
                    state_d      = S_SCHED_GUARD;
                    next_stage_d = NEXT_UART;
                    guard_cnt_d  = '0;
                    owner_d      = OWN_NONE;
                end
            end
            S_SCHED_GUARD: begin
                if (guard_cnt_q == GUARD_LAST) begin
                    wd_d = '0;
                    unique case (next_stage_q)
                        NEXT_UART: begin
                            state_d   = S_SCHED_UART;
                            owner_d   = OWN_UART;
                            uart_en_d = 1'b1;
                        end
                        NEXT_M2: begin
                            state_d = S_SCHED_M2;
                            owner_d = OWN_M2;
                            m2_en_d = 1'b1;
                        end
                        NEXT_M1: begin
                            state_d = S_SCHED_M1;
                            owner_d = OWN_M1;
                            m1_en_d = 1'b1;
                        end
                        NEXT_DISPLAY: begin
                            state_d = S_SCHED_DISPLAY;
                            owner_d = OWN_VGA;
                        end
                    endcase
                end else begin
                    guard_cnt_d = guard_cnt_q + 2'd1;
                end
            end
            S_SCHED_UART, S_SCHED_M2, S_SCHED_M1: begin
                // Done takes priority over a watchdog expiring in the same cycle.
                if (stage_done) begin
                    state_d      = S_SCHED_GUARD;
                    next_stage_d = follow_stage(state_q);
                    guard_cnt_d  = '0;
                    owner_d      = OWN_NONE;
                end else if (wd_q == TIMEOUT_CYCLES - 24'd1) begin
                    state_d = S_SCHED_ERROR;
                    error_d = 1'b1;
                    owner_d = OWN_NONE;
                end else begin
                    wd_d = wd_q + 24'd1;
                end
            end
            // Display and error are terminal until reset.
            default: ;
        endcase
    end

    // State registers; asynchronous reset parks the SRAM port immediately.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q      <= S_SCHED_IDLE;
            next_stage_q <= NEXT_UART;
            owner_q      <= OWN_NONE;
            guard_cnt_q  <= '0;
            wd_q         <= '0;
            uart_en_q    <= 1'b0;
            m2_en_q      <= 1'b0;
            m1_en_q      <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            next_stage_q <= next_stage_d;
            owner_q      <= owner_d;
            guard_cnt_q  <= guard_cnt_d;
            wd_q         <= wd_d;
            uart_en_q    <= uart_en_d;
            m2_en_q      <= m2_en_d;
            m1_en_q      <= m1_en_d;
            error_q      <= error_d;
        end
    end

    // Status outputs.
    always_comb begin
        uart_enable = uart_en_q;
        m2_enable   = m2_en_q;
        m1_enable   = m1_en_q;
        error       = error_q;
        stage       = state_q;
        busy        = (state_q != S_SCHED_IDLE) && (state_q != S_SCHED_DISPLAY);
    end

    sram_port_mux u_sram_port_mux (
        .owner           (owner_q),
        .uart_address    (uart_address),
        .uart_write_data (uart_write_data),
        .uart_we_n       (uart_we_n),
        .m2_address      (m2_address),
        .m2_write_data   (m2_write_data),
        .m2_we_n         (m2_we_n),
        .m1_address      (m1_address),
        .m1_write_data   (m1_write_data),
        .m1_we_n         (m1_we_n),
        .vga_address     (vga_address),
        .SRAM_address    (SRAM_address),
        .SRAM_write_data (SRAM_write_data),
        .SRAM_we_n       (SRAM_we_n)
    );

endmodule

// File: tb/tb_sram_stage_scheduler.sv
// Self-checking bench for sram_stage_scheduler with a short watchdog.
module tb_sram_stage_scheduler;
    import sram_stage_scheduler_pkg::*;

    localparam int unsigned GUARD = 2;
    localparam int unsigned TIMEOUT = 100;

    logic        Clock, Resetn, start;
    logic        uart_enable, uart_done, uart_we_n;
    logic [17:0] uart_address;
    logic [15:0] uart_write_data;
    logic        m2_enable, m2_done, m2_we_n;
    logic [17:0] m2_address;
    logic [15:0] m2_write_data;
    logic        m1_enable, m1_done, m1_we_n;
    logic [17:0] m1_address;
    logic [15:0] m1_write_data;
    logic [17:0] vga_address;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;
    logic [2:0]  stage;
    logic        busy, error;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [2:0]  exp_st;

    sram_stage_scheduler #(
        .TIMEOUT_CYCLES (24'(TIMEOUT)),
        .GUARD_CYCLES   (GUARD)
    ) dut (
        .Clock           (Clock),
        .Resetn          (Resetn),
        .start           (start),
        .uart_enable     (uart_enable),
        .uart_done       (uart_done),
        .uart_address    (uart_address),
        .uart_write_data (uart_write_data),
        .uart_we_n       (uart_we_n),
        .m2_enable       (m2_enable),
        .m2_done         (m2_done),
        .m2_address      (m2_address),
        .m2_write_data   (m2_write_data),
        .m2_we_n         (m2_we_n),
        .m1_enable       (m1_enable),
        .m1_done         (m1_done),
        .m1_address      (m1_address),
        .m1_write_data   (m1_write_data),
        .m1_we_n         (m1_we_n),
        .vga_address     (vga_address),
        .SRAM_address    (SRAM_address),
        .SRAM_write_data (SRAM_write_data),
        .SRAM_we_n       (SRAM_we_n),
        .stage           (stage),
        .busy            (busy),
        .error           (error)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic step();
        @(posedge Clock);
        #2;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rand_buses();
        uart_address    = 18'($urandom);
        uart_write_data = 16'($urandom);
        uart_we_n       = 1'($urandom);
        m2_address      = 18'($urandom);
        m2_write_data   = 16'($urandom);
        m2_we_n         = 1'($urandom);
        m1_address      = 18'($urandom);
        m1_write_data   = 16'($urandom);
        m1_we_n         = 1'($urandom);
        vga_address     = 18'($urandom);
    endtask

    // Expected SRAM bus {we_n, address, data}: the running stage owns the port.
    function automatic logic [34:0] model_bus(input logic [2:0] st);
        if (st == S_SCHED_UART)         model_bus = {uart_we_n, uart_address, uart_write_data};
        else if (st == S_SCHED_M2)      model_bus = {m2_we_n, m2_address, m2_write_data};
        else if (st == S_SCHED_M1)      model_bus = {m1_we_n, m1_address, m1_write_data};
        else if (st == S_SCHED_DISPLAY) model_bus = {1'b1, vga_address, 16'h0};
        else                            model_bus = {1'b1, 18'h0, 16'h0};
    endfunction

    function automatic logic [2:0] model_en(input logic [2:0] st);
        if (st == S_SCHED_UART)    model_en = 3'b100;
        else if (st == S_SCHED_M2) model_en = 3'b010;
        else if (st == S_SCHED_M1) model_en = 3'b001;
        else                       model_en = 3'b000;
    endfunction

    task automatic bus_checks(input int n, input string tag);
        repeat (n) begin
            rand_buses();
            #1;
            check(tag, {SRAM_we_n, SRAM_address, SRAM_write_data}, model_bus(exp_st));
            check({tag, "_stage"}, stage, exp_st);
            step();
        end
    endtask

    // Called in the first guard cycle; walks the guard and checks stage entry.
    task automatic enter_stage(input logic [2:0] st);
        exp_st = S_SCHED_GUARD;
        check("guard_stage", stage, exp_st);
        check("guard_we_n", SRAM_we_n, 1'b1);
        repeat (GUARD - 1) begin
            step();
            check("guard_hold", stage, exp_st);
            check("guard_bus", {SRAM_we_n, SRAM_address, SRAM_write_data}, model_bus(exp_st));
        end
        step();
        exp_st = st;
        check("entry_stage", stage, exp_st);
        check("entry_enable", {uart_enable, m2_enable, m1_enable}, model_en(st));
    endtask

    task automatic pulse_done(input int which);
        uart_done = (which == 0);
        m2_done   = (which == 1);
        m1_done   = (which == 2);
        step();
        uart_done = 1'b0;
        m2_done   = 1'b0;
        m1_done   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Reset, then run the sequence up to entry of the requested compute stage.
    task automatic run_to(input logic [2:0] st);
        Resetn = 1'b0;
        #1;
        exp_st = S_SCHED_IDLE;
        check("rst_stage", stage, exp_st);
        step();
        Resetn = 1'b1;
        step();
        pulse_start();
        enter_stage(S_SCHED_UART);
        if (st != S_SCHED_UART) begin
            pulse_done(0);
            enter_stage(S_SCHED_M2);
            if (st != S_SCHED_M2) begin
                pulse_done(1);
                enter_stage(S_SCHED_M1);
            end
        end
    endtask

    initial begin
        Resetn    = 1'b1;
        start     = 1'b0;
        uart_done = 1'b0;
        m2_done   = 1'b0;
        m1_done   = 1'b0;
        rand_buses();
        exp_st = S_SCHED_IDLE;
        #3 Resetn = 1'b0;
        #1;
        check("rst_stage", stage, exp_st);
        check("rst_bus", {SRAM_we_n, SRAM_address, SRAM_write_data}, {1'b1, 18'h0, 16'h0});
        check("rst_enables", {uart_enable, m2_enable, m1_enable}, 3'b000);
        check("rst_error", error, 1'b0);
        check("rst_busy", busy, 1'b0);
        step();
        Resetn = 1'b1;
        step();
        check("idle_hold", stage, exp_st);

        // Start -> guard for two cycles -> UART with a single enable pulse.
        pulse_start();
        check("guard_busy", busy, 1'b1);
        enter_stage(S_SCHED_UART);
        step();
        check("uart_en_once", {uart_enable, m2_enable, m1_enable}, 3'b000);
        bus_checks(4, "uart_bus");
        pulse_done(2);
        check("foreign_done_uart", stage, exp_st);
        pulse_done(1);
        check("foreign_done_uart2", stage, exp_st);
        pulse_done(0);
        enter_stage(S_SCHED_M2);

        // Directed write in M2; UART write enable must not leak through.
        m2_address    = 18'h1234;
        m2_write_data = 16'hBEEF;
        m2_we_n       = 1'b0;
        uart_we_n     = 1'b0;
        #1;
        check("m2_direct", {SRAM_we_n, SRAM_address, SRAM_write_data}, {1'b0, 18'h1234, 16'hBEEF});
        step();
        pulse_done(2);
        check("m1_done_in_m2", stage, exp_st);
        bus_checks(3, "m2_bus");
        pulse_done(1);
        enter_stage(S_SCHED_M1);

        // Done in the same cycle as the enable pulse is accepted.
        pulse_done(2);
        enter_stage(S_SCHED_DISPLAY);
        uart_we_n = 1'b0;
        m2_we_n   = 1'b0;
        m1_we_n   = 1'b0;
        #1;
        check("vga_we_n", SRAM_we_n, 1'b1);
        check("vga_busy", busy, 1'b0);
        bus_checks(4, "vga_bus");
        pulse_start();
        check("display_start", stage, exp_st);
        pulse_done(2);
        check("display_done", stage, exp_st);

        // Asynchronous reset during an M1 write.
        run_to(S_SCHED_M1);
        m1_we_n = 1'b0;
        #1;
        check("m1_write", SRAM_we_n, 1'b0);
        Resetn = 1'b0;
        #1;
        check("async_we_n", SRAM_we_n, 1'b1);
        check("async_stage", stage, 3'(S_SCHED_IDLE));
        check("async_addr", SRAM_address, 18'h0);
        step();

        // Watchdog: no m2_done, error exactly TIMEOUT cycles after M2 entry.
        run_to(S_SCHED_M2);
        m2_we_n = 1'b0;
        for (int i = 1; i < TIMEOUT; i++) begin
            step();
            check("wd_hold", stage, exp_st);
        end
        check("wd_no_error", error, 1'b0);
        step();
        exp_st = S_SCHED_ERROR;
        check("wd_stage", stage, exp_st);
        check("wd_error", error, 1'b1);
        check("wd_we_n", SRAM_we_n, 1'b1);
        check("wd_busy", busy, 1'b1);
        pulse_start();
        check("err_start", stage, exp_st);
        pulse_done(1);
        check("err_done", stage, exp_st);
        check("err_sticky", error, 1'b1);

        // Done on the expiring cycle wins over the watchdog.
        run_to(S_SCHED_M2);
        repeat (TIMEOUT - 1) step();
        check("edge_stage", stage, exp_st);
        pulse_done(1);
        check("edge_error", error, 1'b0);
        enter_stage(S_SCHED_M1);
        bus_checks(3, "m1_bus");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_stage_scheduler.md
Name: sram_stage_scheduler

Overview:
Top-level sequencer and SRAM port owner for the image decompressor. It runs the stages in a fixed order: UART image load, Milestone 2 (IDCT), Milestone 1 (colour-space conversion / upsampling), then VGA display. At any time exactly one stage drives the single SRAM port. The block starts each stage with an enable pulse, waits for its done pulse, and inserts a guard cycle at every handover. A watchdog reports any stage that never finishes.

Parameters:
TIMEOUT_CYCLES, 24'd4000000, maximum cycles a compute stage (UART, M2, M1) may run before error; DISPLAY is exempt.
GUARD_CYCLES, 2, idle cycles at each handover: SRAM_we_n=1, no owner; legal range 1..3.

Ports:
Clock  input  1  system clock
Resetn  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begins the sequence from S_IDLE
uart_enable  output  1  one-cycle start pulse to UART loader
uart_done  input  1  one-cycle completion pulse
uart_address  input  18  UART SRAM address
uart_write_data  input  16  UART write data
uart_we_n  input  1  UART write enable, active low
m2_enable  output  1  start pulse to Milestone 2
m2_done  input  1  completion pulse
m2_address  input  18  M2 address
m2_write_data  input  16  M2 write data
m2_we_n  input  1  M2 write enable
m1_enable  output  1  start pulse to Milestone 1
m1_done  input  1  completion pulse
m1_address  input  18  M1 address
m1_write_data  input  16  M1 write data
m1_we_n  input  1  M1 write enable
vga_address  input  18  VGA read address; read-only client
SRAM_address  output  18  muxed SRAM address
SRAM_write_data  output  16  muxed write data
SRAM_we_n  output  1  muxed write enable
stage  output  3  current state encoding
busy  output  1  high in any state other than S_IDLE and S_DISPLAY
error  output  1  sticky timeout flag

Behaviour:
- Reset state and outputs:
  - state S_IDLE, owner NONE, all *_enable 0, error 0, watchdog 0.
  - SRAM_address=0, SRAM_write_data=0, SRAM_we_n=1.
- States: S_IDLE, S_GUARD, S_UART, S_M2, S_M1, S_DISPLAY, S_ERROR.
- A 2-bit next_stage register records which stage follows S_GUARD.
- Transitions:
  - S_IDLE --start--> S_GUARD (next=UART).
  - S_UART --uart_done--> S_GUARD (next=M2).
  - S_M2 --m2_done--> S_GUARD (next=M1).
  - S_M1 --m1_done--> S_GUARD (next=DISPLAY).
  - S_GUARD holds for GUARD_CYCLES cycles, then enters next_stage.
- Enable pulses:
  - Asserted for exactly the first cycle in S_UART/S_M2/S_M1, registered.
  - Never held high, so a client returning to its idle state cannot restart itself.
- Done handling:
  - Done is honoured only in the matching state.
  - Done for any other stage, or done in S_GUARD/S_IDLE, is ignored.
  - Done in the same cycle as the enable pulse is accepted.
- Ownership and mux:
  - The owner register is updated on state entry.
  - The mux is combinational from owner, giving zero added latency to SRAM reads/writes.
  - Owner NONE (S_IDLE, S_GUARD, S_ERROR): SRAM_we_n=1, address=0, data=0.
  - Owner VGA: SRAM_we_n forced 1, SRAM_write_data=0, address=vga_address.
- Watchdog:
  - Cleared on entry to each compute state and incremented every cycle in it.
  - On reaching TIMEOUT_CYCLES-1 without done: go to S_ERROR, set error, owner NONE.
  - If done arrives in the same cycle the watchdog expires, done wins.
- S_ERROR and S_DISPLAY:
  - S_ERROR is left only by reset.
  - start is ignored in every state except S_IDLE.
  - S_DISPLAY persists until reset.
- Reset mid-operation: immediate return to reset values.
  - SRAM_we_n goes to 1 asynchronously, so no partial write is extended.

Decomposition:
- Shared package (define_state.h style): typedef enum for scheduler states (S_SCHED_*), owner enum (OWN_NONE, OWN_UART, OWN_M2, OWN_M1, OWN_VGA), SRAM width constants (18/16).
- One natural sub-module: sram_port_mux. It is purely combinational: owner in, client buses in, SRAM bus out.

Test Plan:
- Reset then start at cycle 5 -> S_GUARD for 2 cycles; uart_enable high for exactly 1 cycle at cycle 8; SRAM_we_n=1 during the guard.
- In S_M2, drive m2_address=18'h1234, m2_we_n=0, m2_write_data=16'hBEEF -> SRAM bus shows the same values in the same cycle; uart_we_n=0 has no effect.
- Pulse m1_done while in S_M2 -> ignored, state remains S_M2; a later m2_done -> S_GUARD, then m1_enable pulse.
- With TIMEOUT_CYCLES=100, never assert m2_done -> S_ERROR exactly 100 cycles after S_M2 entry; error=1; SRAM_we_n=1; start ignored.
- Full sequence to S_DISPLAY with vga_we forced low elsewhere -> SRAM_we_n stays 1 and SRAM_address tracks vga_address.
- Assert Resetn=0 mid-write in S_M1 (m1_we_n=0) -> SRAM_we_n=1 without waiting for a clock edge; state S_IDLE.
